// File: rtl/img_proc_pkg.sv
// Shared definitions for the image-processing front end: sequencer FSM
// states, counter sizing helper and the window generator latency.
package img_proc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        FLUSH  = 2'd3
    } seq_state_e;

    // Cycles from a pixel entering the 3x3 window generator to its matrix output.
    localparam int MATRIX_LAT = 2;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/coord_delay_line.sv
// Shifts window-centre coordinates alongside the window generator pipeline.
// A stage only takes new coordinates when a valid window moves into it, so
// the outputs hold the last window while no valid window is present.
module coord_delay_line #(
    parameter int N  = 2,
    parameter int XW = 3,
    parameter int YW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_i,
    input  logic [XW-1:0] cx_i,
    input  logic [YW-1:0] cy_i,
    output logic          vld_o,
    output logic [XW-1:0] cx_o,
    output logic [YW-1:0] cy_o
);

    logic [N-1:0]  vld_p_q;
    logic [XW-1:0] cx_p_q [N];
    logic [YW-1:0] cy_p_q [N];

    // Stage k carries the window that entered the line k+1 cycles ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p_q <= '0;
            for (int k = 0; k < N; k++) begin
                cx_p_q[k] <= '0;
                cy_p_q[k] <= '0;
            end
        end else begin
            vld_p_q[0] <= vld_i;
            if (vld_i) begin
                cx_p_q[0] <= cx_i;
                cy_p_q[0] <= cy_i;
            end
            for (int k = 1; k < N; k++) begin
                vld_p_q[k] <= vld_p_q[k-1];
                if (vld_p_q[k-1]) begin
                    cx_p_q[k] <= cx_p_q[k-1];
                    cy_p_q[k] <= cy_p_q[k-1];
                end
            end
        end
    end

    assign vld_o = vld_p_q[N-1];
    assign cx_o  = cx_p_q[N-1];
    assign cy_o  = cy_p_q[N-1];

endmodule

// File: rtl/matrix_frame_sequencer.sv
// Front-end sequencer for the 3x3 window generator: forwards the pixel
// stream, counts columns/rows, appends one flush line after the frame so the
// bottom row reaches the window centre, and reports the window-centre
// coordinates aligned with the generator's matrix outputs.
module matrix_frame_sequencer
    import img_proc_pkg::*;
#(
    parameter int         IMG_W     = 640,
    parameter int         IMG_H     = 480,
    parameter int         FLUSH_GAP = 16,
    parameter logic [7:0] FLUSH_VAL = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vsync,
    input  logic                     in_href,
    input  logic                     in_clken,
    input  logic [7:0]               in_y,
    output logic                     out_vsync,
    output logic                     out_href,
    output logic                     out_clken,
    output logic [7:0]               out_y,
    output logic                     win_valid,
    output logic                     win_border,
    output logic [$clog2(IMG_W)-1:0] win_cx,
    output logic [$clog2(IMG_H)-1:0] win_cy,
    output logic                     flush_active,
    output logic                     err_line
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam int GW = cnt_w(FLUSH_GAP);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_MAX  = '1;
    localparam logic [CW-1:0] COL_LEN  = CW'(IMG_W);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = '1;
    localparam logic [RW-1:0] ROW_LEN  = RW'(IMG_H);
    localparam logic [GW-1:0] GAP_LAST = GW'((FLUSH_GAP > 0) ? FLUSH_GAP - 1 : 0);
    localparam logic [YW-1:0] CY_LAST  = YW'(IMG_H - 1);

    seq_state_e    state_q, state_d;
    logic          vsync_q, href_prev_q;
    logic [CW-1:0] col_q, col_d, col_inc;
    logic [RW-1:0] row_q, row_d, row_inc;
    logic [GW-1:0] gap_q, gap_d;
    logic          err_q, err_d;
    logic          href_q, href_d, clken_q, clken_d, flush_q, flush_d;
    logic [7:0]    y_q, y_d;
    logic [CW-1:0] col_o_q, col_o_d;
    logic [RW-1:0] row_o_q, row_o_d;
    logic          vs_rise, hf_fall, pix, win_src_vld;

    assign vs_rise = in_vsync & ~vsync_q;
    assign hf_fall = href_prev_q & ~in_href;
    assign pix     = in_href & in_clken;
    assign col_inc = (col_q == COL_MAX) ? col_q : col_q + 1'b1;
    assign row_inc = (row_q == ROW_MAX) ? row_q : row_q + 1'b1;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a vsync rising edge restarts the frame from any state.
    always_comb begin
        state_d = state_q;
        if (vs_rise) begin
            state_d = ACTIVE;
        end else begin
            case (state_q)
                ACTIVE:  if (hf_fall && row_inc == ROW_LEN) state_d = GAP;
                GAP:     if (gap_q == GAP_LAST) state_d = FLUSH;
                FLUSH:   if (col_q == COL_LAST) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs and counters: forwarding, flush generation and error tracking.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        gap_d   = '0;
        err_d   = err_q;
        href_d  = 1'b0;
        clken_d = 1'b0;
        y_d     = y_q;
        flush_d = 1'b0;
        col_o_d = col_o_q;
        row_o_d = row_o_q;
        if (vs_rise) begin
            // Pixel arriving with the vsync edge is column 0 of row 0.
            col_d   = pix ? CW'(1) : '0;
            row_d   = '0;
            err_d   = (state_q == GAP) || (state_q == FLUSH);
            href_d  = in_href;
            clken_d = pix;
            y_d     = in_y;
            col_o_d = '0;
            row_o_d = '0;
        end else begin
            case (state_q)
                ACTIVE: begin
                    href_d  = in_href;
                    clken_d = pix;
                    y_d     = in_y;
                    if (pix) begin
                        col_o_d = col_q;
                        row_o_d = row_q;
                        col_d   = col_inc;
                        if (col_inc == COL_MAX) err_d = 1'b1;
                    end
                    if (hf_fall) begin
                        col_d = '0;
                        row_d = row_inc;
                        if (col_q != COL_LEN || row_inc == ROW_MAX) err_d = 1'b1;
                    end
                end
                GAP: begin
                    gap_d = gap_q + 1'b1;
                    if (in_href) err_d = 1'b1;
                end
                FLUSH: begin
                    href_d  = 1'b1;
                    clken_d = 1'b1;
                    y_d     = FLUSH_VAL;
                    flush_d = 1'b1;
                    col_o_d = col_q;
                    row_o_d = ROW_LEN;
                    col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                    if (in_href) err_d = 1'b1;
                end
                default: begin
                    if (in_href) err_d = 1'b1;
                end
            endcase
        end
    end

    // Registered pass-through, counters and forwarded-pixel coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            href_prev_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            gap_q       <= '0;
            err_q       <= 1'b0;
            href_q      <= 1'b0;
            clken_q     <= 1'b0;
            y_q         <= '0;
            flush_q     <= 1'b0;
            col_o_q     <= '0;
            row_o_q     <= '0;
        end else begin
            vsync_q     <= in_vsync;
            href_prev_q <= in_href;
            col_q       <= col_d;
            row_q       <= row_d;
            gap_q       <= gap_d;
            err_q       <= err_d;
            href_q      <= href_d;
            clken_q     <= clken_d;
            y_q         <= y_d;
            flush_q     <= flush_d;
            col_o_q     <= col_o_d;
            row_o_q     <= row_o_d;
        end
    end

    // A full 3x3 window exists once the newest pixel is at col>=1 and row>=1;
    // its centre is one column left and one row up.
    assign win_src_vld = clken_q && (col_o_q != '0) && (row_o_q != '0);

    coord_delay_line #(
        .N  (MATRIX_LAT),
        .XW (XW),
        .YW (YW)
    ) u_coord_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (win_src_vld),
        .cx_i  (XW'(col_o_q - 1'b1)),
        .cy_i  (YW'(row_o_q - 1'b1)),
        .vld_o (win_valid),
        .cx_o  (win_cx),
        .cy_o  (win_cy)
    );

    assign win_border   = win_valid && (win_cx == '0 || win_cy == '0 || win_cy == CY_LAST);
    assign out_vsync    = vsync_q;
    assign out_href     = href_q;
    assign out_clken    = clken_q;
    assign out_y        = y_q;
    assign flush_active = flush_q;
    assign err_line     = err_q;

endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Directed bench for matrix_frame_sequencer on an 8x4 image.
module tb_matrix_frame_sequencer;

    logic       clk, rst_n;
    logic       in_vsync, in_href, in_clken;
    logic [7:0] in_y;
    logic       out_vsync, out_href, out_clken;
    logic [7:0] out_y;
    logic       win_valid, win_border, flush_active, err_line;
    logic [2:0] win_cx;
    logic [1:0] win_cy;

    int n_chk = 0;
    int n_err = 0;

    // Monitor tallies (written only by the monitor process).
    logic mon_clr = 1'b0;
    int win_cnt, brd_cnt, brd_bad, seq_bad, hold_bad;
    int flush_cnt, data_cnt, low_run, gap_len;
    int first_cx, first_cy, last_cx, last_cy, last_brd, got_first;
    logic       flush_prev;
    logic [2:0] prev_cx;
    logic [1:0] prev_cy;

    // Driver-side records.
    logic href_seen;
    logic first_y_ok;
    logic err_after [4];

    matrix_frame_sequencer #(
        .IMG_W     (8),
        .IMG_H     (4),
        .FLUSH_GAP (16),
        .FLUSH_VAL (8'h00)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_vsync     (in_vsync),
        .in_href      (in_href),
        .in_clken     (in_clken),
        .in_y         (in_y),
        .out_vsync    (out_vsync),
        .out_href     (out_href),
        .out_clken    (out_clken),
        .out_y        (out_y),
        .win_valid    (win_valid),
        .win_border   (win_border),
        .win_cx       (win_cx),
        .win_cy       (win_cy),
        .flush_active (flush_active),
        .err_line     (err_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample the outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_clr) begin
            win_cnt = 0; brd_cnt = 0; brd_bad = 0; seq_bad = 0; hold_bad = 0;
            flush_cnt = 0; data_cnt = 0; low_run = 0; gap_len = -1;
            got_first = 0; first_cx = -1; first_cy = -1;
            last_cx = -1; last_cy = -1; last_brd = -1;
            flush_prev = flush_active;
        end else begin
            if (win_valid) begin
                if (win_border != ((win_cx == 0) || (win_cy == 0) || (win_cy == 3))) brd_bad++;
                if (win_border) brd_cnt++;
                if (int'(win_cx) != win_cnt % 7 || int'(win_cy) != win_cnt / 7) seq_bad++;
                if (got_first == 0) begin
                    first_cx = int'(win_cx);
                    first_cy = int'(win_cy);
                    got_first = 1;
                end
                last_cx  = int'(win_cx);
                last_cy  = int'(win_cy);
                last_brd = int'(win_border);
                win_cnt++;
            end else if (win_cx != prev_cx || win_cy != prev_cy) begin
                hold_bad++;
            end
            if (out_href && out_clken && flush_active && out_y == 8'h00) flush_cnt++;
            if (out_href && out_clken && !flush_active) data_cnt++;
            if (out_href) begin
                if (flush_active && !flush_prev) gap_len = low_run;
                low_run = 0;
            end else begin
                low_run++;
            end
            flush_prev = flush_active;
        end
        prev_cx = win_cx;
        prev_cy = win_cy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic drive_line(input int npix);
        for (int i = 0; i < npix; i++) begin
            in_href  = 1'b1;
            in_clken = 1'b1;
            in_y     = 8'(i + 1);
            tick();
            href_seen = href_seen | out_href;
            if (i == 0) first_y_ok = out_href && (out_y == 8'd1);
        end
        in_href  = 1'b0;
        in_clken = 1'b0;
        in_y     = 8'h00;
    endtask

    task automatic start_frame();
        in_vsync = 1'b1;
        tick();
        in_vsync = 1'b0;
        idle(2);
    endtask

    task automatic send_lines(input int short_row);
        for (int r = 0; r < 4; r++) begin
            drive_line((r == short_row) ? 7 : 8);
            idle(3);
            err_after[r] = err_line;
        end
    endtask

    task automatic wait_flush_start();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (flush_active) seen = 1'b1;
            else tick();
        end
        if (!seen) chk("flush_start_timeout", 0, 1);
    endtask

    task automatic finish_frame();
        wait_flush_start();
        idle(14);
    endtask

    initial begin
        rst_n = 1'b0; in_vsync = 1'b0; in_href = 1'b0; in_clken = 1'b0; in_y = 8'h00;
        href_seen = 1'b0; first_y_ok = 1'b0;
        idle(2);
        chk("reset_outputs", {out_vsync, out_href, out_clken, out_y, win_valid, win_border,
                              win_cx, win_cy, flush_active, err_line}, 0);
        rst_n = 1'b1;
        idle(2);

        // Full frame: windows, borders, gap length and flush line.
        mon_reset();
        in_vsync = 1'b1;
        tick();
        chk("vsync_pass", out_vsync, 1);
        in_vsync = 1'b0;
        idle(2);
        send_lines(-1);
        chk("first_pixel_fwd", first_y_ok, 1);
        finish_frame();
        chk("f1_err_end_lines", err_after[3], 0);
        chk("f1_win_count", win_cnt, 28);
        chk("f1_border_count", brd_cnt, 16);
        chk("f1_border_map", brd_bad, 0);
        chk("f1_win_order", seq_bad, 0);
        chk("f1_hold", hold_bad, 0);
        chk("f1_last_cx", last_cx, 6);
        chk("f1_last_cy", last_cy, 3);
        chk("f1_last_border", last_brd, 1);
        chk("f1_data_pixels", data_cnt, 32);
        chk("f1_flush_pixels", flush_cnt, 8);
        // Low stretch = the href-fall cycle that enters GAP plus 16 GAP cycles.
        chk("f1_gap_len", gap_len, 17);
        chk("f1_err_final", err_line, 0);

        // Short line on row 2.
        mon_reset();
        start_frame();
        send_lines(2);
        chk("short_err_before", err_after[1], 0);
        chk("short_err_after", err_after[2], 1);
        finish_frame();
        chk("short_flush_pixels", flush_cnt, 8);
        chk("short_err_final", err_line, 1);

        // Extra line during GAP.
        mon_reset();
        start_frame();
        send_lines(-1);
        chk("extra_err_clean", err_after[3], 0);
        href_seen = 1'b0;
        drive_line(4);
        idle(1);
        chk("extra_not_fwd", href_seen, 0);
        chk("extra_err", err_line, 1);
        finish_frame();
        chk("extra_flush_pixels", flush_cnt, 8);

        // Overrun: vsync edge on the third flush cycle.
        start_frame();
        send_lines(-1);
        wait_flush_start();
        tick();
        in_vsync = 1'b1;
        tick();
        chk("abort_href", out_href, 0);
        chk("abort_flush", flush_active, 0);
        chk("abort_err", err_line, 1);
        in_vsync = 1'b0;
        idle(3);
        mon_reset();
        send_lines(-1);
        finish_frame();
        chk("abort_win_count", win_cnt, 28);
        chk("abort_first_cx", first_cx, 0);
        chk("abort_first_cy", first_cy, 0);
        chk("abort_win_order", seq_bad, 0);
        chk("abort_err_kept", err_line, 1);

        // Reset during the flush line.
        start_frame();
        send_lines(-1);
        wait_flush_start();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flush", {out_vsync, out_href, out_clken, out_y, win_valid, win_border,
                              win_cx, win_cy, flush_active, err_line}, 0);
        idle(2);
        rst_n = 1'b1;
        mon_reset();
        idle(30);
        chk("rst_no_flush", data_cnt + flush_cnt, 0);
        start_frame();
        send_lines(-1);
        finish_frame();
        chk("rst_clean_err", err_line, 0);
        chk("rst_clean_wins", win_cnt, 28);
        chk("rst_clean_flush", flush_cnt, 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
